// File: rtl/vector_pkg.sv
// Shared definitions for the vector command decoder: opcodes, packet
// geometry, FIFO entry layout and parser state encoding.
package vector_pkg;

  localparam logic [1:0] OP_JUMP   = 2'b00;
  localparam logic [1:0] OP_DRAW   = 2'b01;

  localparam int HDR_BIT   = 7;
  localparam int PKT_LEN   = 5;
  localparam int COORD_W   = 12;
  localparam int PAYLOAD_W = 6;
  localparam int ENTRY_W   = 26;

  // One parser state per byte position in a packet.
  typedef enum logic [$clog2(PKT_LEN)-1:0] {
    ST_HDR,
    ST_XH,
    ST_XL,
    ST_YH,
    ST_YL
  } parse_state_e;

  // FIFO entry: opcode in the top bits, then X, then Y.
  typedef struct packed {
    logic [1:0]         op;
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
  } cmd_entry_t;

  // Only jump and draw are executable; the other two codes are reserved.
  function automatic logic is_valid_op(input logic [1:0] op);
    return (op == OP_JUMP) || (op == OP_DRAW);
  endfunction

endpackage

// File: rtl/vector_cmd_decoder_fifo.sv
// Synchronous command FIFO. The head entry is read combinationally from
// storage, but a pushed entry only counts as present from the next cycle.
module cmd_fifo #(
  parameter int WIDTH = 26,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       wdata,
  output logic [WIDTH-1:0]       rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [LW-1:0]    count_r;
  logic             wr_en_s;
  logic             rd_en_s;

  assign full  = (count_r == LW'(DEPTH));
  assign empty = (count_r == {LW{1'b0}});
  assign level = count_r;
  assign rdata = mem_r[rd_ptr_r];

  // A push into a full FIFO is still taken when a pop frees the head slot.
  always_comb begin
    rd_en_s = pop && !empty;
    wr_en_s = push && (!full || rd_en_s);
  end

  // Storage array, written at the tail on an accepted push.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_r[wr_ptr_r] <= wdata;
    end
  end

  // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {LW{1'b0}};
    end else begin
      if (wr_en_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (rd_en_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({wr_en_s, rd_en_s})
        2'b10:   count_r <= count_r + LW'(1);
        2'b01:   count_r <= count_r - LW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/vector_cmd_decoder.sv
// Decodes 5-byte UART packets into jump/draw commands, buffers them in a
// FIFO and issues them to the line controller with a post-issue guard window.
module vector_cmd_decoder
  import vector_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int GUARD = 2
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   rx_dv,
  input  logic [7:0]             rx_byte,
  input  logic                   ready,
  input  logic                   clear,
  output logic [COORD_W-1:0]     x,
  output logic [COORD_W-1:0]     y,
  output logic                   draw,
  output logic                   jump,
  output logic [$clog2(DEPTH):0] level,
  output logic                   overflow,
  output logic                   proto_err
);

  localparam int GW = $clog2(GUARD + 1);

  parse_state_e         state_r, state_s;
  logic [1:0]           op_r, op_s;
  logic [PAYLOAD_W-1:0] xh_r, xh_s;
  logic [PAYLOAD_W-1:0] xl_r, xl_s;
  logic [PAYLOAD_W-1:0] yh_r, yh_s;
  logic                 push_s;
  logic                 perr_s;
  logic                 is_hdr_s;
  cmd_entry_t           push_entry_s;
  cmd_entry_t           head_s;
  logic [ENTRY_W-1:0]   fifo_rdata_s;
  logic                 fifo_full_s;
  logic                 fifo_empty_s;
  logic                 issue_s;
  logic                 ovf_set_s;
  logic [GW-1:0]        guard_r;
  logic [COORD_W-1:0]   x_r, y_r;
  logic                 draw_r, jump_r;
  logic                 overflow_r;
  logic                 proto_err_r;
  logic                 unused_byte_bit_s;

  // Bit 6 is don't-care in both header and data bytes.
  assign unused_byte_bit_s = rx_byte[6];

  assign is_hdr_s     = rx_byte[HDR_BIT];
  assign push_entry_s = cmd_entry_t'({op_r, xh_r, xl_r, yh_r, rx_byte[PAYLOAD_W-1:0]});
  assign head_s       = cmd_entry_t'(fifo_rdata_s);

  // Packet parser: a header byte always restarts a packet; data bytes fill fields.
  always_comb begin
    state_s = state_r;
    op_s    = op_r;
    xh_s    = xh_r;
    xl_s    = xl_r;
    yh_s    = yh_r;
    push_s  = 1'b0;
    perr_s  = 1'b0;
    if (!rx_dv) begin
      state_s = state_r;
    end else if (is_hdr_s) begin
      perr_s  = (state_r != ST_HDR);
      op_s    = rx_byte[1:0];
      state_s = ST_XH;
    end else begin
      case (state_r)
        ST_HDR: state_s = ST_HDR;
        ST_XH: begin
          xh_s    = rx_byte[PAYLOAD_W-1:0];
          state_s = ST_XL;
        end
        ST_XL: begin
          xl_s    = rx_byte[PAYLOAD_W-1:0];
          state_s = ST_YH;
        end
        ST_YH: begin
          yh_s    = rx_byte[PAYLOAD_W-1:0];
          state_s = ST_YL;
        end
        ST_YL: begin
          if (is_valid_op(op_r)) begin
            push_s = 1'b1;
          end else begin
            perr_s = 1'b1;
          end
          state_s = ST_HDR;
        end
        default: state_s = ST_HDR;
      endcase
    end
  end

  // Parser state and partially assembled packet fields.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= ST_HDR;
      op_r    <= 2'b00;
      xh_r    <= {PAYLOAD_W{1'b0}};
      xl_r    <= {PAYLOAD_W{1'b0}};
      yh_r    <= {PAYLOAD_W{1'b0}};
    end else begin
      state_r <= state_s;
      op_r    <= op_s;
      xh_r    <= xh_s;
      xl_r    <= xl_s;
      yh_r    <= yh_s;
    end
  end

  cmd_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (push_s),
    .pop     (issue_s),
    .wdata   (push_entry_s),
    .rdata   (fifo_rdata_s),
    .full    (fifo_full_s),
    .empty   (fifo_empty_s),
    .level   (level)
  );

  // Issue when a command is waiting, the controller is ready and the guard has expired.
  always_comb begin
    issue_s   = !fifo_empty_s && ready && (guard_r == {GW{1'b0}});
    ovf_set_s = push_s && fifo_full_s && !issue_s;
  end

  // Issue stage: latch coordinates and fire a one-cycle draw or jump pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      x_r    <= {COORD_W{1'b0}};
      y_r    <= {COORD_W{1'b0}};
      draw_r <= 1'b0;
      jump_r <= 1'b0;
    end else if (issue_s) begin
      x_r    <= head_s.x;
      y_r    <= head_s.y;
      draw_r <= (head_s.op == OP_DRAW);
      jump_r <= (head_s.op == OP_JUMP);
    end else begin
      draw_r <= 1'b0;
      jump_r <= 1'b0;
    end
  end

  // Guard window masks ready while the controller is still reacting to the last issue.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      guard_r <= {GW{1'b0}};
    end else if (issue_s) begin
      guard_r <= GW'(GUARD);
    end else if (guard_r != {GW{1'b0}}) begin
      guard_r <= guard_r - GW'(1);
    end else begin
      guard_r <= guard_r;
    end
  end

  // Status flags: sticky overflow (clear wins) and registered protocol-error pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overflow_r  <= 1'b0;
      proto_err_r <= 1'b0;
    end else begin
      if (clear) begin
        overflow_r <= 1'b0;
      end else if (ovf_set_s) begin
        overflow_r <= 1'b1;
      end
      proto_err_r <= perr_s;
    end
  end

  assign x         = x_r;
  assign y         = y_r;
  assign draw      = draw_r;
  assign jump      = jump_r;
  assign overflow  = overflow_r;
  assign proto_err = proto_err_r;

endmodule

// File: doc/vector_cmd_decoder.md
# vector_cmd_decoder

Decodes the byte stream delivered by the UART receiver into vector commands and issues them to the line-draw controller over its `x`/`y`/`draw`/`jump`/`ready` handshake. It replaces the hard-coded test pattern in the top level. Decoded commands are buffered in a small FIFO so that UART arrival and beam drawing rates are decoupled. The block sits between `uart_rx` and `control`.

## Interface
- `DEPTH`, 16: FIFO entries; power of two, minimum 2.
- `GUARD`, 2: cycles after an issue pulse during which `ready` is ignored; minimum 1.
- `clk` in 1: system clock.
- `reset_n` in 1: reset, asynchronous and active-low. One clock; reset is asynchronous and active-low.
- `rx_dv` in 1: one-cycle byte-valid strobe from `uart_rx`.
- `rx_byte` in 8: received byte; valid only when `rx_dv` is high.
- `ready` in 1: line controller can accept a command.
- `x` out 12: command X coordinate; held between commands.
- `y` out 12: command Y coordinate; held between commands.
- `draw` out 1: one-cycle pulse that draws a line to (`x`,`y`).
- `jump` out 1: one-cycle pulse that moves the beam to (`x`,`y`) with the beam blanked.
- `level` out $clog2(DEPTH)+1: FIFO occupancy.
- `overflow` out 1: sticky flag, set when a complete packet is dropped because the FIFO is full.
- `proto_err` out 1: one-cycle pulse on a malformed or reserved packet.
- `clear` in 1: synchronous clear of `overflow`.

## Operation
- **Packet format.** Each packet is 5 bytes: header, XH, XL, YH, YL.
  - Header: bit7 = 1, bits[1:0] = opcode (00 jump, 01 draw, 10/11 reserved), bits[6:2] ignored.
  - Data bytes: bit7 = 0, bit6 ignored, bits[5:0] carry payload.
  - `x = {XH[5:0], XL[5:0]}`; `y = {YH[5:0], YL[5:0]}`.
- **Parser states:** `HDR`, `XH`, `XL`, `YH`, `YL`. The parser advances only on `rx_dv`.
  - In `HDR`: a byte with bit7 = 0 is discarded silently.
  - In `XH`..`YL`: a byte with bit7 = 1 pulses `proto_err`, abandons the partial packet, and is taken as a new header (next state `XH`).
  - The packet completes on the `YL` byte:
    - Opcode 00/01: push {op, x, y} into the FIFO.
    - Reserved opcode: no push; pulse `proto_err`.
    - Either way, return to `HDR`.
- **FIFO.**
  - A push while full is dropped and sets `overflow`, unless a pop occurs in the same cycle; in that case the push is accepted.
  - A pop from empty is impossible by construction.
  - No fall-through: a pushed entry becomes poppable on the next cycle.
- **Issue.**
  - Issue condition: FIFO non-empty, `ready` high, and the guard counter at zero.
  - On an issue edge:
    - Pop the head entry.
    - Register `x`/`y`.
    - Assert `draw` (op 01) or `jump` (op 00) for exactly one cycle.
    - Load the guard counter with `GUARD`.
  - The guard counter decrements to 0. This covers the controller's `ready` deassert latency.
  - `draw` and `jump` are never high together.
- `clear` takes priority over a same-cycle overflow set.

## Timing
- **Reset values (asynchronous assert):** `x` = 0, `y` = 0, `draw` = 0, `jump` = 0, `level` = 0, `overflow` = 0, `proto_err` = 0; parser in `HDR`; guard counter 0.
- **Reset released mid-packet:** the partial packet is lost; the parser restarts in `HDR`.
- **Latency:**
  - `rx_dv` with the `YL` byte in cycle T → entry in FIFO at cycle T+1 (`level` increments).
  - With `ready` high, `draw`/`jump` is high in cycle T+2, with `x`/`y` valid in the same cycle.
- **Throughput:** at most one issue per GUARD+1 cycles. With `ready` held high continuously and `GUARD` = 2, pulses occur every 3 cycles.
- `x`/`y` change only on issue edges.
- `proto_err` is asserted in the cycle after the offending `rx_dv`.

## Structure
- Shared package `vector_pkg`:
  - opcode constants `OP_JUMP` = 2'b00, `OP_DRAW` = 2'b01
  - `HDR_BIT` = 7
  - `PKT_LEN` = 5
  - coordinate width 12
  - FIFO entry width 26 (2-bit op + 24-bit coordinates)
- Sub-module `cmd_fifo`: synchronous FIFO with parameters `WIDTH` and `DEPTH`; asynchronous active-low reset; `push`/`pop`/`full`/`empty`/`level`. The parser and issue logic stay in the top module.

## Test plan
- **Draw packet:** send 0x81,0x3F,0x3F,0x06,0x10 with `ready` = 1 → one `draw` pulse with `x` = 4095, `y` = 400 at T+2; `jump` stays 0.
- **Back-pressure:** send jump(0,0) then draw(100,200) with `ready` = 0 → `level` = 2, no pulses. Raise `ready` → `jump` with (0,0), then `draw` with (100,200) exactly GUARD+1 cycles later.
- **Resync:** send 0x81,0x01,0x80,0x00,0x00,0x00,0x05 → `proto_err` pulses once; a single jump to (0,5) is issued.
- **Reserved opcode and stray data:** send 0x12, then 0x82,0,0,0,0 → no push; `proto_err` pulses once, for the 0x82 packet only.
- **Overflow:** with `ready` = 0, send DEPTH+1 valid packets → `level` = DEPTH and `overflow` = 1. Pulse `clear` → `overflow` = 0. Raise `ready` → exactly DEPTH commands are issued, in order.
- **Reset mid-packet:** assert `reset_n` = 0 after 3 bytes → all outputs return to their reset values immediately. Release `reset_n`, then send a full packet → exactly one command is issued.
